request_encoder_8to3: RTL and testbench
=======================================

// Module: request_encoder_8to3
// PURPOSE
// - Registered 8-to-3 request encoder. It is the inverse of the 3-to-8 lamp/phase select decoder.
// - Collects sticky per-lane requests (sensors, pedestrian buttons) and grants one lane at a time.
// - Presents the granted lane as a 3-bit index with valid, and holds it until the controller FSM acks.
// - Sits between the lane request inputs and the traffic controller's phase-select decoder.
// PARAMETERS
// - N_REQ  8  number of request lines. Legal values: 2..8.
// - IDX_W  3  index width, equal to $clog2(N_REQ). Not to be overridden independently.
// PORTS
// - clk      in   1      system clock, rising edge
// - reset    in   1      asynchronous, active-high reset
// - req      in   N_REQ  request pulses or levels; bit i = lane i; sampled every cycle
// - ack      in   1      controller has consumed the current grant
// - idx      out  IDX_W  granted lane index
// - valid    out  1      idx holds a live grant
// - pending  out  N_REQ  sticky request register (observability)
// BEHAVIOUR
// - Reset (async, immediate):
//   - pending = 0, idx = 0, valid = 0, state = IDLE.
//   - last = N_REQ-1, so the first round-robin search starts at lane 0.
// - Pending register, updated every edge:
//   - pending <= (pending & ~clr) | req
//   - clr = onehot(idx) when (valid & ack), else 0.
//   - Set dominates: a req on the bit being cleared in the same cycle keeps that bit set.
// - FSM with 2 states, IDLE and GRANT:
//   - IDLE: if pending != 0, load idx = selected lane, valid <= 1, go to GRANT. Otherwise stay, valid = 0.
//   - GRANT: idx and valid are held stable while ack = 0.
//   - GRANT with ack = 1: clear pending[idx], last <= idx, valid <= 0, go to IDLE.
//   - A mandatory 1-cycle valid-low bubble separates consecutive grants.
// - Selection uses the registered pending value only; req arriving in the same cycle is not visible to that selection.
// - Latency:
//   - req sampled at edge E0 gives valid=1 after edge E1 (2 edges, idle case).
//   - ack sampled at edge Ek gives valid=0 after Ek; the next grant is earliest after Ek+1.
// - ack while valid = 0 is ignored, with no state change.
// - idx keeps its last value while valid = 0. Consumers must qualify idx with valid.
// - All-lanes-requesting: each lane is granted exactly once per N_REQ grants (round-robin mode).
// - A request on a lane already pending merges into it; there is no counting.
// - Reset asserted mid-grant drops valid immediately and discards all pending requests.
// - Bits of req at or above N_REQ do not exist; when N_REQ < 8, idx never exceeds N_REQ-1.
// CONFIGURATION
// - Macro REQ_ENC_ROUND_ROBIN_EN.
// - Defined: rotating priority. Search starts at (last+1) mod N_REQ, increments, and wraps at N_REQ-1 to 0.
//   The first set bit found wins. last updates only on an accepted ack.
// - Undefined: fixed priority; the lowest set index wins. The last register and its logic are removed.
//   Starvation of high lanes under sustained low-lane requests is accepted in this mode.
// - Port list, latency and the bubble are identical in both builds.
// TESTING
// 1. Reset check:
//    - Stimulus: reset high mid-run with pending = 8'hFF, valid = 1.
//    - Required: pending = 0, valid = 0, idx = 0 immediately, without waiting for a clock edge.
// 2. Single request:
//    - Stimulus: req = 8'b0010_0000 for one cycle at E0, ack held low.
//    - Required: valid = 1, idx = 5 after E1; held for 10 cycles.
//    - Stimulus: ack at Ek.
//    - Required: valid = 0 and pending = 0 after Ek.
// 3. Multiple requests, fixed priority (macro undefined):
//    - Stimulus: req = 8'b1000_0101 together, ack each grant.
//    - Required: grant order 0, 2, 7, with valid low for 1 cycle between grants.
// 4. Round-robin wrap (macro defined):
//    - Stimulus: first grant lane 6 and ack it; then req = 8'b0100_0011 together.
//    - Required: grant order 0, 1, 6. Next, req = 8'hFF continuously.
//    - Required: lanes 7, 0, 1, ... 6, each exactly once per 8 grants.
// 5. Simultaneous set and clear:
//    - Stimulus: grant idx = 3, then ack together with req[3] = 1.
//    - Required: pending[3] stays 1, valid = 0 for the bubble, then lane 3 is re-granted (if it is the only pending lane).
// 6. Spurious ack:
//    - Stimulus: ack = 1 while valid = 0 and pending = 0.
//    - Required: no change to pending, idx or last.
//    - Stimulus: then req[4].
//    - Required: idx = 4 after 2 edges.

Source files
------------

// File: rtl/request_encoder_8to3_if.sv
// Request/grant bus between lane requesters, the traffic controller and the request encoder.
// The master side drives req/ack; the slave side (the encoder) returns idx/valid/pending.
interface request_encoder_8to3_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic             ack;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic [N_REQ-1:0] pending;

    modport master (output req, output ack, input idx, input valid, input pending);
    modport slave  (input req, input ack, output idx, output valid, output pending);
endinterface

// File: rtl/request_encoder_8to3.sv
// Registered 8-to-3 request encoder: sticky lane requests, one grant at a time, held until ack.
// Define REQ_ENC_ROUND_ROBIN_EN for rotating priority; otherwise the lowest pending lane wins.
module request_encoder_8to3 #(
    parameter int N_REQ = 8,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    request_encoder_8to3_if.slave bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;
    logic [N_REQ-1:0] clr;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] sel_idx;
    logic             valid_q;
    logic             accept;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q;
    int               lane;
`endif

    assign accept = (state_q == GRANT) && bus.ack;
    assign clr    = accept ? (N_REQ'(1) << idx_q) : '0;

    // A new request on the lane being cleared this cycle survives the clear.
    assign pending_d = (pending_q & ~clr) | bus.req;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel_idx = '0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
        lane = 0;
        // Walk from the farthest offset to the nearest so the first set lane after last_q wins.
        for (int off = N_REQ; off >= 1; off--) begin
            lane = (int'(last_q) + off) % N_REQ;
            if (pending_q[lane]) sel_idx = IDX_W'(lane);
        end
`else
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = IDX_W'(i);
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            last_q    <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (pending_q != '0) begin
                        idx_q   <= sel_idx;
                        valid_q <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
`ifdef REQ_ENC_ROUND_ROBIN_EN
                        last_q  <= idx_q;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.idx     = idx_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_request_encoder_8to3.sv
// Self-checking bench for request_encoder_8to3: directed scenarios plus random traffic,
// compared every cycle against a grant-level reference model.
module tb_request_encoder_8to3;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;

    request_encoder_8to3_if #(.N_REQ(N)) bus ();

    request_encoder_8to3 #(.N_REQ(N)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the set of waiting lanes, the current grant, and the last served lane.
    logic [N-1:0] m_pending;
    int           m_idx;
    bit           m_valid;
    int           m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] p, input int last);
        int  winner = 0;
        bit  found  = 1'b0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (!found && p[(last + k) % N]) begin
                winner = (last + k) % N;
                found  = 1'b1;
            end
        end
`else
        for (int l = 0; l < N; l++) begin
            if (!found && p[l]) begin
                winner = l;
                found  = 1'b1;
            end
        end
`endif
        return winner;
    endfunction

    task automatic model_reset();
        m_pending = '0;
        m_idx     = 0;
        m_valid   = 1'b0;
        m_last    = N - 1;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic a);
        logic [N-1:0] next_pending;
        next_pending = m_pending;
        if (m_valid && a) next_pending[m_idx] = 1'b0;
        next_pending = next_pending | r;
        if (!m_valid) begin
            if (m_pending != '0) begin
                m_idx   = pick(m_pending, m_last);
                m_valid = 1'b1;
            end
        end else if (a) begin
            m_valid = 1'b0;
            m_last  = m_idx;
        end
        m_pending = next_pending;
    endtask

    task automatic step(input logic [N-1:0] r, input logic a);
        @(negedge clk);
        bus.req = r;
        bus.ack = a;
        @(posedge clk);
        model_edge(r, a);
        #1;
        check("pending", 32'(bus.pending), 32'(m_pending));
        check("valid", 32'(bus.valid), 32'(m_valid));
        check("idx", 32'(bus.idx), 32'(m_idx));
    endtask

    // Waits (bounded) for a grant, records its lane, then acks it.
    task automatic next_grant(input logic [N-1:0] r, output int lane);
        lane = -1;
        for (int c = 0; c < 10 && lane < 0; c++) begin
            if (bus.valid) lane = int'(bus.idx);
            else step(r, 1'b0);
        end
        if (lane < 0) begin
            check("grant_timeout", 32'(bus.valid), 32'd1);
        end else begin
            step(r, 1'b1);
            check("bubble_valid", 32'(bus.valid), 32'd0);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset   = 1'b1;
        bus.req = '0;
        bus.ack = 1'b0;
        #1;
        model_reset();
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_idx", 32'(bus.idx), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int lane;
        int exp_lane;
        int exp3[3];
        int exp4[3];

        reset   = 1'b1;
        bus.req = '0;
        bus.ack = 1'b0;
        model_reset();
        #1;
        check("init_pending", 32'(bus.pending), 32'd0);
        check("init_valid", 32'(bus.valid), 32'd0);
        check("init_idx", 32'(bus.idx), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single request on lane 5, held until ack.
        step(8'b0010_0000, 1'b0);
        check("single_e0_valid", 32'(bus.valid), 32'd0);
        step('0, 1'b0);
        check("single_valid", 32'(bus.valid), 32'd1);
        check("single_idx", 32'(bus.idx), 32'd5);
        for (int i = 0; i < 10; i++) begin
            step('0, 1'b0);
            check("single_hold_idx", 32'(bus.idx), 32'd5);
        end
        step('0, 1'b1);
        check("single_ack_valid", 32'(bus.valid), 32'd0);
        check("single_ack_pending", 32'(bus.pending), 32'd0);

        // Reset mid-grant with every lane pending.
        step(8'hFF, 1'b0);
        step('0, 1'b0);
        check("pre_rst_valid", 32'(bus.valid), 32'd1);
        check("pre_rst_pending", 32'(bus.pending), 32'hFF);
        async_reset();

        // Three lanes together; after reset the search starts at lane 0 in both builds.
        exp3 = '{0, 2, 7};
        step(8'b1000_0101, 1'b0);
        for (int g = 0; g < 3; g++) begin
            next_grant('0, lane);
            check("multi_order", 32'(lane), 32'(exp3[g]));
        end

        // Grant lane 6, then lanes 0, 1, 6 requested together.
        step(8'b0100_0000, 1'b0);
        next_grant('0, lane);
        check("lane6_first", 32'(lane), 32'd6);
        exp4 = '{0, 1, 6};
        step(8'b0100_0011, 1'b0);
        for (int g = 0; g < 3; g++) begin
            next_grant('0, lane);
            check("wrap_order", 32'(lane), 32'(exp4[g]));
        end

        // All lanes requesting continuously.
        for (int g = 0; g < 2 * N; g++) begin
            next_grant(8'hFF, lane);
`ifdef REQ_ENC_ROUND_ROBIN_EN
            exp_lane = (7 + g) % N;
`else
            exp_lane = 0;
`endif
            check("all_req_order", 32'(lane), 32'(exp_lane));
        end
        async_reset();

        // Ack of lane 3 coinciding with a fresh request on lane 3.
        step(8'b0000_1000, 1'b0);
        step('0, 1'b0);
        check("setclr_grant_idx", 32'(bus.idx), 32'd3);
        step(8'b0000_1000, 1'b1);
        check("setclr_pending3", 32'(bus.pending[3]), 32'd1);
        check("setclr_bubble", 32'(bus.valid), 32'd0);
        step('0, 1'b0);
        check("setclr_regrant_valid", 32'(bus.valid), 32'd1);
        check("setclr_regrant_idx", 32'(bus.idx), 32'd3);
        step('0, 1'b1);

        // Ack while nothing is granted.
        step('0, 1'b1);
        check("spur_pending", 32'(bus.pending), 32'd0);
        check("spur_valid", 32'(bus.valid), 32'd0);
        check("spur_idx", 32'(bus.idx), 32'd3);
        step(8'b0001_0000, 1'b0);
        step('0, 1'b0);
        check("spur_then_valid", 32'(bus.valid), 32'd1);
        check("spur_then_idx", 32'(bus.idx), 32'd4);
        step('0, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step(r, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
